muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle RV32M/RV64M multiply/divide unit for the EX stage. It sits beside the single-cycle ALU and takes all eight M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) through a start/ready/valid handshake. Division uses an iterative radix-2 restoring datapath. Multiplication is either iterative shift-add or single-cycle, selected at compile time. Divide-by-zero and signed overflow follow the RISC-V spec exactly, replacing the ALU's zero-result shortcut.

## Interface
- XLEN, 32, operand/result width (32 or 64)
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, do not override)

- CLK  in  1  clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- START  in  1  request; accepted only when READY=1
- SELECT  in  5  op code, `MUL..`REMU from utils/encordings.v; other codes yield RESULT=0 after one step
- DATA1  in  XLEN  rs1 operand (multiplicand/dividend)
- DATA2  in  XLEN  rs2 operand (multiplier/divisor)
- KILL  in  1  pipeline flush; aborts any in-flight op
- READY  out  1  unit idle, will accept START this cycle
- BUSY  out  1  op in flight (state != IDLE)
- VALID  out  1  one-cycle pulse: RESULT is new
- RESULT  out  XLEN  result, held until the next VALID

## Operation
- States:
  - IDLE: READY=1.
  - CALC: one iteration per cycle.
  - FIN: sign fix and result select.
- IDLE->CALC on START with an iterative op.
- IDLE->FIN on START with a special case or a fast-multiply op.
- CALC->FIN when the counter reaches 0.
- FIN->IDLE always; on that edge RESULT is registered and VALID is set.
- At acceptance, DATA1, DATA2 and SELECT are latched. Signed operands are converted to magnitudes and their sign flags are stored.
- Signedness per op:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: DATA1 signed, DATA2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: sign-agnostic low half.
- Multiply: 2*XLEN-bit product. MUL returns bits [XLEN-1:0]; MULH, MULHSU, MULHU return [2*XLEN-1:XLEN]. The product is negated in FIN when the operand signs differ.
- Divide: quotient takes the sign of the XOR of the operand signs; remainder takes the sign of the dividend.
- Divisor == 0 (DIV, DIVU, REM, REMU): quotient = all ones, remainder = DATA1. Goes straight to FIN.
- DIV/REM with DATA1 = most-negative and DATA2 = all ones: quotient = DATA1, remainder = 0. Goes straight to FIN.
- START while READY=0 is ignored; the in-flight op is not disturbed.
- KILL (any state other than IDLE): next state IDLE, no VALID, RESULT unchanged.
- KILL and START in the same cycle: KILL wins and START is dropped.
- RESET_N low: immediately forces IDLE, which also aborts any in-flight op.

## Timing
- Reset values:
  - RESULT = 0, VALID = 0, BUSY = 0, READY = 1.
  - State = IDLE, counter = 0.
- READY and BUSY are decoded combinationally from the state register; VALID and RESULT are registered.
- Latency is measured from the edge that accepts START to the edge that raises VALID.
  - Iterative op: XLEN+2 cycles (1 load, XLEN iterations, 1 FIN). This is 34 for XLEN=32.
  - Special case, or fast multiply: 2 cycles.
- READY is high during the VALID cycle, so a new START can be accepted back-to-back with no bubble.
- Throughput is one op per XLEN+2 cycles.

## Configuration
- MULDIV_FAST_MUL_EN defined: the multiply ops bypass CALC and compute the full 2*XLEN product combinationally in FIN, with a latency of 2.
- MULDIV_FAST_MUL_EN undefined: multiplication is shift-add through CALC, with a latency of XLEN+2.
- Division is iterative in both builds.

## Test plan
XLEN=32 unless noted; the bench runs with the macro both defined and undefined.
- DIV with DATA1=0xFFFFFFF9 (-7) and DATA2=2 -> RESULT=0xFFFFFFFD after 34 cycles. REM with the same operands -> 0xFFFFFFFF.
- DIVU with DATA1=100 and DATA2=0 -> RESULT=0xFFFFFFFF after 2 cycles. REMU with the same operands -> 0x00000064.
- Signed overflow cases, each after 2 cycles:
  - DIV 0x80000000 / 0xFFFFFFFF -> RESULT=0x80000000.
  - REM with the same operands -> RESULT=0.
- Multiply high halves:
  - MULH 0x80000000 * 0x80000000 -> RESULT=0x40000000.
  - MULHU 0xFFFFFFFF * 0xFFFFFFFF -> RESULT=0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF * 0xFFFFFFFF -> RESULT=0xFFFFFFFF.
  - MUL 0xFFFFFFFF * 0xFFFFFFFF -> RESULT=0x00000001.
  - Latency is 34 cycles without the macro and 2 with it.
- Abort and handshake:
  - START DIV, then pulse KILL 5 cycles later -> VALID never rises; READY=1 on the next cycle.
  - START pulsed while BUSY -> ignored.
  - RESET_N dropped mid-op -> all outputs return to their reset values immediately.
- Back-to-back: assert START with DIVU 10/3 in the VALID cycle of the previous op -> accepted; the next VALID comes 34 cycles later with RESULT=3.

Source files
------------

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: restoring radix-2 divider, shift-add or single-cycle multiplier.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply in FIN instead of iterating in CALC).
// Handshake: START is taken only on a cycle where READY=1 and KILL=0; VALID pulses for exactly one cycle with a new RESULT.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            START,
    input  logic [4:0]      SELECT,
    input  logic [XLEN-1:0] DATA1,
    input  logic [XLEN-1:0] DATA2,
    input  logic            KILL,
    output logic            READY,
    output logic            BUSY,
    output logic            VALID,
    output logic [XLEN-1:0] RESULT,
    output logic [1:0]      DBG_STATE
);

    localparam logic [4:0] SEL_MUL    = 5'd0;
    localparam logic [4:0] SEL_MULH   = 5'd1;
    localparam logic [4:0] SEL_MULHSU = 5'd2;
    localparam logic [4:0] SEL_MULHU  = 5'd3;
    localparam logic [4:0] SEL_DIV    = 5'd4;
    localparam logic [4:0] SEL_DIVU   = 5'd5;
    localparam logic [4:0] SEL_REM    = 5'd6;
    localparam logic [4:0] SEL_REMU   = 5'd7;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          sel_q, sel_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic                spec_q, spec_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                valid_q, valid_d;

    // Request decode, evaluated on the operands presented with START.
    logic            op_ok_in, is_mul_in, is_div_in, sgn_a_in, sgn_b_in;
    logic            neg_a_in, neg_b_in, div_zero_in, ovf_in, spec_in, iter_in;
    logic [XLEN-1:0] mag_a_in, mag_b_in, spec_res_in;

    assign op_ok_in    = (SELECT <= SEL_REMU);
    assign is_mul_in   = (SELECT <= SEL_MULHU);
    assign is_div_in   = op_ok_in && !is_mul_in;
    assign sgn_a_in    = (SELECT == SEL_MULH) || (SELECT == SEL_MULHSU) ||
                         (SELECT == SEL_DIV)  || (SELECT == SEL_REM);
    assign sgn_b_in    = (SELECT == SEL_MULH) || (SELECT == SEL_DIV) || (SELECT == SEL_REM);
    assign neg_a_in    = sgn_a_in && DATA1[XLEN-1];
    assign neg_b_in    = sgn_b_in && DATA2[XLEN-1];
    assign mag_a_in    = neg_a_in ? -DATA1 : DATA1;
    assign mag_b_in    = neg_b_in ? -DATA2 : DATA2;
    assign div_zero_in = is_div_in && (DATA2 == '0);
    assign ovf_in      = ((SELECT == SEL_DIV) || (SELECT == SEL_REM)) &&
                         (DATA1 == {1'b1, {(XLEN-1){1'b0}}}) && (DATA2 == '1);
    assign spec_in     = !op_ok_in || div_zero_in || ovf_in;
    assign iter_in     = !spec_in && !(FAST_MUL && is_mul_in);

    always_comb begin
        spec_res_in = '0;
        if (div_zero_in) begin
            spec_res_in = ((SELECT == SEL_DIV) || (SELECT == SEL_DIVU)) ? '1 : DATA1;
        end else if (ovf_in) begin
            spec_res_in = (SELECT == SEL_DIV) ? DATA1 : '0;
        end
    end

    // One iteration of each datapath; acc_q holds {high, low} for multiply and {rem, quo} for divide.
    logic            is_mul_q;
    logic [XLEN:0]   mul_hi_sum;
    logic [XLEN:0]   div_trial;
    logic [XLEN-1:0] div_rem_nx;
    logic [2*XLEN-1:0] mul_step, div_step;

    assign is_mul_q   = (sel_q <= SEL_MULHU);
    assign mul_hi_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, a_q & {XLEN{acc_q[0]}}};
    assign mul_step   = {mul_hi_sum, acc_q[XLEN-1:1]};
    assign div_trial  = acc_q[2*XLEN-1:XLEN-1] - {1'b0, b_q};
    assign div_rem_nx = div_trial[XLEN] ? acc_q[2*XLEN-2:XLEN-1] : div_trial[XLEN-1:0];
    assign div_step   = {div_rem_nx, acc_q[XLEN-2:0], ~div_trial[XLEN]};

    logic [2*XLEN-1:0] prod_mag, prod;
    logic [XLEN-1:0]   quo, rem, fin_res;

`ifdef MULDIV_FAST_MUL_EN
    assign prod_mag = {{XLEN{1'b0}}, a_q} * {{XLEN{1'b0}}, b_q};
`else
    assign prod_mag = acc_q;
`endif

    assign prod = (neg_a_q ^ neg_b_q) ? -prod_mag : prod_mag;
    assign quo  = acc_q[XLEN-1:0];
    assign rem  = acc_q[2*XLEN-1:XLEN];

    always_comb begin
        fin_res = '0;
        if (spec_q) begin
            fin_res = acc_q[XLEN-1:0];
        end else begin
            case (sel_q)
                SEL_MUL:                        fin_res = prod[XLEN-1:0];
                SEL_MULH, SEL_MULHSU, SEL_MULHU: fin_res = prod[2*XLEN-1:XLEN];
                SEL_DIV, SEL_DIVU:              fin_res = (neg_a_q ^ neg_b_q) ? -quo : quo;
                SEL_REM, SEL_REMU:              fin_res = neg_a_q ? -rem : rem;
                default:                        fin_res = '0;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        spec_d   = spec_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START && !KILL) begin
                    sel_d   = SELECT;
                    a_d     = mag_a_in;
                    b_d     = mag_b_in;
                    neg_a_d = neg_a_in;
                    neg_b_d = neg_b_in;
                    spec_d  = spec_in;
                    if (spec_in) begin
                        acc_d = {{XLEN{1'b0}}, spec_res_in};
                    end else begin
                        acc_d = {{XLEN{1'b0}}, is_mul_in ? mag_b_in : mag_a_in};
                    end
                    state_d = iter_in ? S_CALC : S_FIN;
                    cnt_d   = iter_in ? CNT_W'(XLEN) : '0;
                end
            end
            S_CALC: begin
                if (KILL) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = is_mul_q ? mul_step : div_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                if (!KILL) begin
                    result_d = fin_res;
                    valid_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            spec_q   <= 1'b0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            spec_q   <= spec_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign READY     = (state_q == S_IDLE);
    assign BUSY      = (state_q != S_IDLE);
    assign VALID     = valid_q;
    assign RESULT    = result_q;
    assign DBG_STATE = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (XLEN=32): directed spec vectors, randomized ops against an arithmetic model, abort/handshake checks.
module tb_muldiv_unit;

    localparam int ITER_LAT = 34;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif

    logic        CLK;
    logic        RESET_N;
    logic        START;
    logic [4:0]  SELECT;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        KILL;
    logic        READY;
    logic        BUSY;
    logic        VALID;
    logic [31:0] RESULT;
    logic [1:0]  DBG_STATE;

    muldiv_unit #(.XLEN(32)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(START), .SELECT(SELECT),
        .DATA1(DATA1), .DATA2(DATA2), .KILL(KILL), .READY(READY),
        .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT), .DBG_STATE(DBG_STATE)
    );

    // Clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          t_q[$];
    string       nm_q[$];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, expv, cyc);
        end
    endtask

    // Reference model: plain RISC-V M-extension arithmetic on 64-bit integers.
    function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        t  = '0;
        case (sel)
            5'd0: begin t = {32'b0, a} * {32'b0, b}; return t[31:0]; end
            5'd1: begin t = sa * sb; return t[63:32]; end
            5'd2: begin t = sa * ub; return t[63:32]; end
            5'd3: begin t = {32'b0, a} * {32'b0, b}; return t[63:32]; end
            5'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                t = sa / sb; return t[31:0];
            end
            5'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                t = sa % sb; return t[31:0];
            end
            5'd7: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic int lat_model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
        if (sel > 5'd7) return 2;
        if (sel < 5'd4) return MUL_LAT;
        if (b == 0) return 2;
        if ((sel == 5'd4 || sel == 5'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return ITER_LAT;
    endfunction

    // Driver: called at a negedge; waits for READY, presents one request for one cycle.
    task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input bit track, input logic [31:0] expv, input string nm);
        int g = 0;
        while (!READY && g < 200) begin
            @(negedge CLK);
            g++;
        end
        if (!READY) begin
            n_cmp++;
            n_fail++;
            $display("FAIL issue_timeout_%s: READY stayed 0, expected 1", nm);
            return;
        end
        START  = 1'b1;
        SELECT = sel;
        DATA1  = a;
        DATA2  = b;
        if (track) begin
            exp_q.push_back(expv);
            lat_q.push_back(lat_model(sel, a, b));
            t_q.push_back(cyc);
            nm_q.push_back(nm);
        end
        @(negedge CLK);
        START = 1'b0;
        DATA1 = $urandom;
        DATA2 = $urandom;
    endtask

    task automatic drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 300) begin
            @(negedge CLK);
            g++;
        end
        chk("drain_outstanding", 64'(exp_q.size()), 64'd0);
        exp_q.delete(); lat_q.delete(); t_q.delete(); nm_q.delete();
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] corners [5];
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 20));
        return $urandom;
    endfunction

    // Scoreboard monitor
    always @(negedge CLK) begin
        logic [31:0] ev;
        int          el, et;
        string       en;
        if (RESET_N && VALID) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: RESULT=%0h with no request outstanding", RESULT);
            end else begin
                ev = exp_q.pop_front();
                el = lat_q.pop_front();
                et = t_q.pop_front();
                en = nm_q.pop_front();
                chk({en, "_result"}, 64'(RESULT), 64'(ev));
                chk({en, "_latency"}, 64'(cyc - et), 64'(el));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

    initial begin
        int vcount;
        logic [4:0]  s;
        logic [31:0] a, b;
        RESET_N = 1'b0;
        START   = 1'b0;
        KILL    = 1'b0;
        SELECT  = '0;
        DATA1   = '0;
        DATA2   = '0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("reset_result", 64'(RESULT), 64'd0);
        chk("reset_valid", 64'(VALID), 64'd0);
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_ready", 64'(READY), 64'd1);
        chk("reset_state", 64'(DBG_STATE), 64'd0);

        // Directed vectors with hand-derived results
        issue(5'd4, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, "div_m7_2");
        issue(5'd6, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, "rem_m7_2");
        issue(5'd5, 32'd100, 32'd0, 1, 32'hFFFF_FFFF, "divu_by0");
        issue(5'd7, 32'd100, 32'd0, 1, 32'h0000_0064, "remu_by0");
        issue(5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
        issue(5'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0000_0000, "rem_ovf");
        issue(5'd1, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, "mulh_min");
        issue(5'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, "mulhu_max");
        issue(5'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, "mulhsu_m1");
        issue(5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h0000_0001, "mul_m1");
        issue(5'd4, 32'hFFFF_FF9C, 32'd0, 1, 32'hFFFF_FFFF, "div_by0");
        issue(5'd6, 32'hFFFF_FF9C, 32'd0, 1, 32'hFFFF_FF9C, "rem_by0");
        issue(5'd9, 32'd5, 32'd6, 1, 32'h0, "bad_code");
        drain();

        // Randomized ops, issued back-to-back as soon as READY allows
        for (int i = 0; i < 60; i++) begin
            s = ($urandom_range(0, 9) > 7) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            a = rnd_operand();
            b = rnd_operand();
            issue(s, a, b, 1, model(s, a, b), "rand");
        end
        drain();

        // KILL five cycles into a divide: no VALID, idle next cycle
        issue(5'd4, 32'hFFFF_FFF9, 32'd2, 0, 32'h0, "kill_div");
        repeat (4) @(negedge CLK);
        chk("kill_busy_before", 64'(BUSY), 64'd1);
        KILL = 1'b1;
        @(negedge CLK);
        KILL = 1'b0;
        chk("kill_ready", 64'(READY), 64'd1);
        chk("kill_busy", 64'(BUSY), 64'd0);

        // KILL together with START: request dropped
        START = 1'b1; KILL = 1'b1; SELECT = 5'd5; DATA1 = 32'd9; DATA2 = 32'd0;
        @(negedge CLK);
        START = 1'b0; KILL = 1'b0;
        chk("kill_start_busy", 64'(BUSY), 64'd0);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (VALID) vcount++;
        end
        chk("kill_no_valid", 64'(vcount), 64'd0);

        // START while busy is ignored
        issue(5'd5, 32'd1000, 32'd7, 1, 32'd142, "divu_busy");
        START = 1'b1; SELECT = 5'd5; DATA1 = 32'd9; DATA2 = 32'd0;
        @(negedge CLK);
        START = 1'b0;
        drain();

        // Back-to-back: second request presented in the first op's VALID cycle
        issue(5'd7, 32'd1000, 32'd7, 1, 32'd6, "remu_first");
        vcount = 0;
        while (!READY && vcount < 200) begin
            @(negedge CLK);
            vcount++;
        end
        chk("b2b_valid_cycle", 64'(VALID), 64'd1);
        issue(5'd5, 32'd10, 32'd3, 1, 32'd3, "b2b_divu");
        drain();

        // Asynchronous reset mid-op
        issue(5'd4, 32'd12345, 32'd7, 0, 32'h0, "reset_div");
        repeat (3) @(negedge CLK);
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_result", 64'(RESULT), 64'd0);
        chk("arst_valid", 64'(VALID), 64'd0);
        chk("arst_busy", 64'(BUSY), 64'd0);
        chk("arst_ready", 64'(READY), 64'd1);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        issue(5'd0, 32'd6, 32'd7, 1, 32'd42, "post_reset_mul");
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
